// File: rtl/dcache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped write-back data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;
    localparam int INDEX_W    = 3;
    localparam int WORD_OFF_W = 2;
    localparam int TAG_W      = 30 - INDEX_W - WORD_OFF_W;
    localparam int BLOCK_W    = 128;
    localparam int LINES      = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;
endpackage

// File: rtl/dcache_responder_if.sv
// CPU data port plus block-wide main-memory port of the data cache.
// Latency: n/a (wiring only).
// Backpressure: proc_stall holds the CPU; mem_ready completes a memory request.
// slave  : the cache (answers the CPU, drives memory requests)
// master : the environment (CPU and main-memory model)
interface dcache_responder_if;
    logic                         proc_read;
    logic                         proc_write;
    logic [29:0]                  proc_addr;
    logic [31:0]                  proc_wdata;
    logic [31:0]                  proc_rdata;
    logic                         proc_stall;
    logic                         mem_read;
    logic                         mem_write;
    logic [27:0]                  mem_addr;
    logic [dcache_pkg::BLOCK_W-1:0] mem_wdata;
    logic [dcache_pkg::BLOCK_W-1:0] mem_rdata;
    logic                         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the cache, one line per index.
// Latency: combinational read by index; word write and line fill land on the next edge.
// Backpressure: none; the caller never issues a fill and a word write together.
// Ports: idx_i selects the line for read, write and fill; *_o is the selected line;
//        wr_* writes one word and marks dirty; fill_* loads a clean valid line.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_W-1:0]    idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [BLOCK_W-1:0]    data_o,
    input  logic                  wr_en_i,
    input  logic [WORD_OFF_W-1:0] wr_off_i,
    input  logic [31:0]           wr_word_i,
    input  logic                  fill_en_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [BLOCK_W-1:0]    fill_data_i
);
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Only the status bits are reset; a line is ignored until valid anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (wr_en_i) begin
            data_q[idx_i][{wr_off_i, 5'b0} +: 32] <= wr_word_i;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back write-allocate data cache between CPU and block memory.
// Latency: hits complete in the request cycle; misses stall through WRITEBACK/ALLOCATE.
// Backpressure: proc_stall high on any miss until the refilled line hits in IDLE.
// Ports: clk, rst_n (async active-low), bus (slave side of dcache_responder_if).
module dcache_responder
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    dcache_responder_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WB    = WRITEBACK;
    localparam logic [1:0] ST_ALLOC = ALLOCATE;

    logic [1:0]            state_q, state_d;
    logic [WORD_OFF_W-1:0] off;
    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid, line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  hit, req, in_idle, miss, wr_en, fill_en;

    assign off = bus.proc_addr[1:0];
    assign idx = bus.proc_addr[INDEX_W+1:2];
    assign tag = bus.proc_addr[29:INDEX_W+2];

    dcache_line_store u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .wr_en_i     (wr_en),
        .wr_off_i    (off),
        .wr_word_i   (bus.proc_wdata),
        .fill_en_i   (fill_en),
        .fill_tag_i  (tag),
        .fill_data_i (bus.mem_rdata)
    );

    assign hit     = line_valid && (line_tag == tag);
    assign req     = bus.proc_read || bus.proc_write;
    assign in_idle = (state_q == ST_IDLE);
    assign miss    = in_idle && req && !hit;
    // A store miss waits for the fill, then hits and merges here like any store.
    assign wr_en   = in_idle && bus.proc_write && hit;
    assign fill_en = (state_q == ST_ALLOC) && bus.mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (miss) state_d = (line_valid && line_dirty) ? ST_WB : ST_ALLOC;
            ST_WB:    if (bus.mem_ready) state_d = ST_ALLOC;
            ST_ALLOC: if (bus.mem_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Reset gates the stall so a request held during reset does not stall the CPU.
    assign bus.proc_stall = rst_n && (!in_idle || miss);
    // Stores win over an (illegal) simultaneous load, so rdata stays zero then.
    assign bus.proc_rdata = (in_idle && bus.proc_read && !bus.proc_write && hit)
                          ? line_data[{off, 5'b0} +: 32] : 32'd0;

    assign bus.mem_write = (state_q == ST_WB);
    assign bus.mem_read  = (state_q == ST_ALLOC);
    assign bus.mem_wdata = bus.mem_write ? line_data : '0;

    always_comb begin
        bus.mem_addr = '0;
        case (state_q)
            ST_WB:    bus.mem_addr = {line_tag, idx};
            ST_ALLOC: bus.mem_addr = bus.proc_addr[29:2];
            default:  bus.mem_addr = '0;
        endcase
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench: flat-memory golden model plus directed access sequence.
// Latency: memory model answers with mem_ready in the 3rd cycle of each request.
// Backpressure: CPU side holds each request until proc_stall drops.
module tb_dcache_responder;
    import dcache_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_responder_if bus();
    dcache_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Main memory contents (updated by writebacks) and the architectural
    // word view the CPU must observe (every store it has completed).
    logic [127:0] backing [bit [27:0]];
    logic [31:0]  gold    [bit [29:0]];

    logic [27:0]  ev_addr [$];
    bit           ev_wr   [$];
    logic [127:0] ev_data [$];
    int stray_req_cnt  = 0;
    int stray_done_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_blk(input logic [27:0] b);
        logic [127:0] blk;
        if (b == 28'h4) return {32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 4; i++) blk[i*32 +: 32] = 32'hA000_0000 | {2'b00, b, 2'(i)};
        return blk;
    endfunction

    function automatic logic [127:0] blk_rd(input logic [27:0] b);
        if (backing.exists(b)) return backing[b];
        return init_blk(b);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [29:0] a);
        logic [127:0] blk;
        if (gold.exists(a)) return gold[a];
        blk = blk_rd(a[29:2]);
        return blk[{a[1:0], 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] gold_blk(input logic [27:0] b);
        logic [127:0] blk;
        for (int i = 0; i < 4; i++) blk[i*32 +: 32] = gold_rd({b, 2'(i)});
        return blk;
    endfunction

    // Main-memory model. A writeback is committed one cycle after its ready
    // pulse so the checker can compare it against the golden view first.
    initial begin
        int           cnt;
        bit           pend_wr;
        logic [27:0]  pend_addr;
        logic [127:0] pend_data;
        cnt = 0;
        pend_wr = 0;
        pend_addr = '0;
        pend_data = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                pend_wr = 0;
                bus.mem_ready = 1'b0;
            end else begin
                if (pend_wr) begin
                    backing[pend_addr] = pend_data;
                    pend_wr = 0;
                end
                if (bus.mem_ready) begin
                    bus.mem_ready = 1'b0;
                    cnt = 0;
                end
                if (stray_req_cnt > stray_done_cnt) begin
                    bus.mem_ready = 1'b1;
                    stray_done_cnt++;
                end else if (bus.mem_read || bus.mem_write) begin
                    cnt++;
                    if (cnt == LAT) begin
                        bus.mem_ready = 1'b1;
                        ev_addr.push_back(bus.mem_addr);
                        ev_wr.push_back(bus.mem_write);
                        ev_data.push_back(bus.mem_wdata);
                        if (bus.mem_write) begin
                            pend_wr   = 1;
                            pend_addr = bus.mem_addr;
                            pend_data = bus.mem_wdata;
                        end else begin
                            bus.mem_rdata = blk_rd(bus.mem_addr);
                        end
                    end
                end
            end
        end
    end

    // Every-cycle checker against the golden word view.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rst_stall", 128'(bus.proc_stall), 128'(0));
                chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
                chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
                chk("rst_rdata", 128'(bus.proc_rdata), 128'(0));
                gold.delete();  // dirty lines are lost on reset
            end else begin
                chk("mem_rw_exclusive", 128'(bus.mem_read && bus.mem_write), 128'(0));
                if (!bus.mem_read && !bus.mem_write)
                    chk("mem_addr_idle", 128'(bus.mem_addr), 128'(0));
                if (bus.mem_read)
                    chk("alloc_addr", 128'(bus.mem_addr), 128'(bus.proc_addr[29:2]));
                if (bus.mem_write && bus.mem_ready)
                    chk("wb_data", bus.mem_wdata, gold_blk(bus.mem_addr));
                if (bus.proc_read && !bus.proc_write && !bus.proc_stall)
                    chk("rdata", 128'(bus.proc_rdata), 128'(gold_rd(bus.proc_addr)));
                else
                    chk("rdata_zero", 128'(bus.proc_rdata), 128'(0));
                if (bus.proc_write && !bus.proc_stall)
                    gold[bus.proc_addr] = bus.proc_wdata;
            end
        end
    end

    // Entered and left just after a rising edge.
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rd);
        bit done;
        bus.proc_read  = !wr;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wr ? d : 32'd0;
        stalls = 0;
        rd = '0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!bus.proc_stall) begin
                rd = bus.proc_rdata;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) chk("access_timeout", 128'(stalls), 128'(0));
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    initial begin
        int          s;
        logic [31:0] r;
        int          base;
        bit          seen;

        rst_n = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_addr", 128'(bus.mem_addr), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_stall", 128'(bus.proc_stall), 128'(0));
        chk("idle_mem_read", 128'(bus.mem_read), 128'(0));
        @(posedge clk);
        #1;

        // Cold read miss
        base = ev_addr.size();
        access(0, 30'h10, 32'd0, s, r);
        chk("cold_stall", 128'(s), 128'(4));
        chk("cold_rdata", 128'(r), 128'(32'h11));
        chk("cold_nev", 128'(ev_addr.size() - base), 128'(1));
        if (ev_addr.size() == base + 1) begin
            chk("cold_ev_rd", 128'(ev_wr[base]), 128'(0));
            chk("cold_ev_addr", 128'(ev_addr[base]), 128'(28'h4));
        end

        // Read hit
        base = ev_addr.size();
        access(0, 30'h11, 32'd0, s, r);
        chk("hit_stall", 128'(s), 128'(0));
        chk("hit_rdata", 128'(r), 128'(32'h22));
        chk("hit_nev", 128'(ev_addr.size() - base), 128'(0));

        // Write hit
        access(1, 30'h12, 32'hDEADBEEF, s, r);
        chk("wrhit_stall", 128'(s), 128'(0));
        chk("wrhit_nev", 128'(ev_addr.size() - base), 128'(0));

        // Conflicting read -> dirty eviction then allocate
        base = ev_addr.size();
        access(0, 30'h32, 32'd0, s, r);
        chk("dirty_stall", 128'(s), 128'(7));
        chk("dirty_rdata", 128'(r), 128'(32'hA000_0032));
        chk("dirty_nev", 128'(ev_addr.size() - base), 128'(2));
        if (ev_addr.size() == base + 2) begin
            chk("wb_first", 128'(ev_wr[base]), 128'(1));
            chk("wb_addr", 128'(ev_addr[base]), 128'(28'h4));
            chk("wb_word2", 128'(ev_data[base][95:64]), 128'(32'hDEADBEEF));
            chk("wb_word0", 128'(ev_data[base][31:0]), 128'(32'h11));
            chk("alloc_second", 128'(ev_wr[base+1]), 128'(0));
            chk("alloc_addr_c", 128'(ev_addr[base+1]), 128'(28'hC));
        end

        // Write miss allocate, then read back the merged word
        base = ev_addr.size();
        access(1, 30'h101, 32'h12345678, s, r);
        chk("wrmiss_stall", 128'(s), 128'(4));
        chk("wrmiss_nev", 128'(ev_addr.size() - base), 128'(1));
        if (ev_addr.size() == base + 1)
            chk("wrmiss_addr", 128'(ev_addr[base]), 128'(28'h40));
        access(0, 30'h101, 32'd0, s, r);
        chk("wrmiss_rd_stall", 128'(s), 128'(0));
        chk("wrmiss_rd_data", 128'(r), 128'(32'h12345678));

        // Written-back word comes back from memory
        access(0, 30'h12, 32'd0, s, r);
        chk("refetch_stall", 128'(s), 128'(4));
        chk("refetch_rdata", 128'(r), 128'(32'hDEADBEEF));

        // Reset in the middle of ALLOCATE
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h204;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.mem_read;
        end
        chk("midrst_reached_alloc", 128'(seen), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_read", 128'(bus.mem_read), 128'(0));
        chk("midrst_stall", 128'(bus.proc_stall), 128'(0));
        bus.proc_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 30'h12, 32'd0, s, r);
        chk("postrst_stall", 128'(s), 128'(4));
        chk("postrst_rdata", 128'(r), 128'(32'hDEADBEEF));

        // Stray mem_ready while idle
        base = ev_addr.size();
        stray_req_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stray_mem_read", 128'(bus.mem_read), 128'(0));
            chk("stray_mem_write", 128'(bus.mem_write), 128'(0));
            chk("stray_stall", 128'(bus.proc_stall), 128'(0));
        end
        chk("stray_delivered", 128'(stray_done_cnt), 128'(stray_req_cnt));
        @(posedge clk);
        #1;
        access(0, 30'h12, 32'd0, s, r);
        chk("stray_hit_stall", 128'(s), 128'(0));
        chk("stray_hit_rdata", 128'(r), 128'(32'hDEADBEEF));
        chk("stray_nev", 128'(ev_addr.size() - base), 128'(0));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
